y86_alu: RTL and testbench

- 64-bit two's-complement ALU for the Y86 pipeline execute stage; performs ADD, SUB, AND, XOR selected by a 2-bit control code.
- Registers the result, a signed-overflow flag and Y86 condition codes (ZF, SF, OF) one cycle after an accepted operation.
- Fed by the execute stage (operand A = valB and operand B = valA for OPq SUB, so SUB yields valB - valA); outputs feed valE and the CC register.

---
 rtl/y86_alu.sv | 160 ++++++++++++++++
 tb/tb_y86_alu.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/y86_alu.sv
// Y86 execute-stage ALU: ADD/SUB/XOR/AND with registered result and condition codes.
// Optional macro Y86_COND_EVAL_EN adds ifun/cc_update/cnd branch-condition evaluation.
module y86_alu #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [1:0]       control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef Y86_COND_EVAL_EN
    input  logic [3:0]       ifun,
    input  logic [0:0]       cc_update,
    output logic [0:0]       cnd,
`endif
    output logic [WIDTH-1:0] end_result,
    output logic             carry_overflow,
    output logic             out_valid,
    output logic             zf,
    output logic             sf,
    output logic             of
);

    localparam int MSB = WIDTH - 1;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    logic [WIDTH-1:0] alu_res_s;
    logic             alu_ovf_s;

    logic [WIDTH-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic             zf_q, zf_d;
    logic             sf_q, sf_d;
    logic             of_q, of_d;

`ifdef Y86_COND_EVAL_EN
    logic             cnd_q, cnd_d;

    // Condition is evaluated against the flags held before this operation updates them.
    function automatic logic cond_eval(input logic [3:0] fn, input logic z, input logic s, input logic o);
        logic r;
        case (fn)
            4'd0:    r = 1'b1;
            4'd1:    r = (s ^ o) | z;
            4'd2:    r = s ^ o;
            4'd3:    r = z;
            4'd4:    r = ~z;
            4'd5:    r = ~(s ^ o);
            4'd6:    r = ~(s ^ o) & ~z;
            default: r = 1'b0;
        endcase
        return r;
    endfunction
`endif

    // Combinational datapath; SUB is a + ~b + 1 so the same adder form covers both.
    always_comb begin
        alu_res_s = {WIDTH{1'b0}};
        alu_ovf_s = 1'b0;
        case (control)
            OP_ADD: begin
                alu_res_s = a + b;
                alu_ovf_s = (a[MSB] == b[MSB]) && (alu_res_s[MSB] != a[MSB]);
            end
            OP_SUB: begin
                alu_res_s = a + ~b + WIDTH'(1);
                alu_ovf_s = (a[MSB] != b[MSB]) && (alu_res_s[MSB] != a[MSB]);
            end
            OP_XOR: begin
                alu_res_s = a ^ b;
                alu_ovf_s = 1'b0;
            end
            OP_AND: begin
                alu_res_s = a & b;
                alu_ovf_s = 1'b0;
            end
            default: begin
                alu_res_s = {WIDTH{1'b0}};
                alu_ovf_s = 1'b0;
            end
        endcase
    end

    // Next-state: load on an accepted operation, otherwise hold.
    always_comb begin
        result_d    = result_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        zf_d        = zf_q;
        sf_d        = sf_q;
        of_d        = of_q;
`ifdef Y86_COND_EVAL_EN
        cnd_d       = cnd_q;
`endif
        if (in_valid) begin
            result_d    = alu_res_s;
            ovf_d       = alu_ovf_s;
            out_valid_d = 1'b1;
`ifdef Y86_COND_EVAL_EN
            cnd_d       = cond_eval(ifun, zf_q, sf_q, of_q);
            if (cc_update[0]) begin
                zf_d = (alu_res_s == {WIDTH{1'b0}});
                sf_d = alu_res_s[MSB];
                of_d = alu_ovf_s;
            end else begin
                zf_d = zf_q;
                sf_d = sf_q;
                of_d = of_q;
            end
`else
            zf_d        = (alu_res_s == {WIDTH{1'b0}});
            sf_d        = alu_res_s[MSB];
            of_d        = alu_ovf_s;
`endif
        end else begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset taking priority over in_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q    <= {WIDTH{1'b0}};
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            zf_q        <= 1'b0;
            sf_q        <= 1'b0;
            of_q        <= 1'b0;
`ifdef Y86_COND_EVAL_EN
            cnd_q       <= 1'b0;
`endif
        end else begin
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            zf_q        <= zf_d;
            sf_q        <= sf_d;
            of_q        <= of_d;
`ifdef Y86_COND_EVAL_EN
            cnd_q       <= cnd_d;
`endif
        end
    end

    assign end_result     = result_q;
    assign carry_overflow = ovf_q;
    assign out_valid      = out_valid_q;
    assign zf             = zf_q;
    assign sf             = sf_q;
    assign of             = of_q;
`ifdef Y86_COND_EVAL_EN
    assign cnd            = cnd_q;
`endif

endmodule

// File: tb/tb_y86_alu.sv
// Self-checking bench for y86_alu: directed vector table, corner sequences, randomized model check.
module tb_y86_alu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  control;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] end_result;
    logic        carry_overflow;
    logic        out_valid;
    logic        zf;
    logic        sf;
    logic        of;

    int vectors;
    int miscompares;

    y86_alu #(.WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .control(control),
        .a(a), .b(b), .end_result(end_result), .carry_overflow(carry_overflow),
        .out_valid(out_valid), .zf(zf), .sf(sf), .of(of)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  ctrl;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] r;
        logic        zf;
        logic        sf;
        logic        of;
    } vec_t;

    vec_t tbl[8];

    // Reference: exact signed arithmetic in 65 bits; overflow when the true result leaves 64-bit range.
    function automatic void model(input logic [1:0] c, input logic [63:0] x, input logic [63:0] y,
                                  output logic [63:0] r, output logic o);
        logic signed [64:0] wide;
        r = 64'd0;
        o = 1'b0;
        case (c)
            2'b00: begin wide = $signed({x[63], x}) + $signed({y[63], y}); r = wide[63:0]; o = wide[64] ^ wide[63]; end
            2'b01: begin wide = $signed({x[63], x}) - $signed({y[63], y}); r = wide[63:0]; o = wide[64] ^ wide[63]; end
            2'b10: r = x ^ y;
            default: r = x & y;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] er, input logic ezf, input logic esf,
                         input logic eof, input logic ev);
        vectors++;
        if (end_result !== er || zf !== ezf || sf !== esf || of !== eof ||
            carry_overflow !== eof || out_valid !== ev) begin
            miscompares++;
            $display("FAIL %s: got r=%h zf=%b sf=%b of=%b co=%b v=%b, want r=%h zf=%b sf=%b of=%b v=%b",
                     name, end_result, zf, sf, of, carry_overflow, out_valid, er, ezf, esf, eof, ev);
        end
    endtask

    task automatic issue(input logic v, input logic [1:0] c, input logic [63:0] x, input logic [63:0] y);
        in_valid = v;
        control  = c;
        a        = x;
        b        = y;
        @(posedge clk);
        #1;
    endtask

    logic [63:0] exp_r, ra, rb;
    logic        exp_zf, exp_sf, exp_of, o, v;
    logic [1:0]  c;

    function automatic logic [63:0] pick();
        logic [63:0] val;
        case ($urandom_range(0, 7))
            0: val = 64'h7FFF_FFFF_FFFF_FFFF;
            1: val = 64'h8000_0000_0000_0000;
            2: val = 64'd0;
            3: val = 64'hFFFF_FFFF_FFFF_FFFF;
            4: val = 64'd1;
            default: val = {$urandom, $urandom};
        endcase
        return val;
    endfunction

    initial begin
        vectors     = 0;
        miscompares = 0;
        tbl[0] = '{"add_5_3",   2'b00, 64'd5, 64'd3, 64'd8, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{"sub_3_5",   2'b01, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{"sub_7_7",   2'b01, 64'd7, 64'd7, 64'd0, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{"add_ovf",   2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1};
        tbl[4] = '{"sub_ovf",   2'b01, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{"and_logic", 2'b11, 64'hF0F0, 64'hFF00, 64'hF000, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{"xor_logic", 2'b10, 64'hF0F0, 64'hFF00, 64'h0FF0, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{"add_carry_ignored", 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0, 1'b0};

        // Reset held two cycles with an operation presented: it must be discarded.
        rst_n = 1'b0;
        issue(1'b1, 2'b00, 64'd5, 64'd3);
        issue(1'b1, 2'b00, 64'd5, 64'd3);
        check("reset", 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            issue(1'b1, tbl[i].ctrl, tbl[i].a, tbl[i].b);
            check(tbl[i].name, tbl[i].r, tbl[i].zf, tbl[i].sf, tbl[i].of, 1'b1);
        end

        // Back-to-back then idle hold.
        issue(1'b1, 2'b00, 64'd1, 64'd1);
        check("b2b_add", 64'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(1'b1, 2'b01, 64'd4, 64'd1);
        check("b2b_sub", 64'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(1'b1, 2'b11, 64'd6, 64'd3);
        check("b2b_and", 64'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(1'b0, 2'b00, 64'd9, 64'd9);
        check("idle_hold", 64'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(1'b0, 2'b01, 64'd0, 64'd9);
        check("idle_hold2", 64'd2, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized run against the reference model, with idle cycles interleaved.
        exp_r = 64'd2; exp_zf = 1'b0; exp_sf = 1'b0; exp_of = 1'b0;
        for (int i = 0; i < 400; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            c  = 2'($urandom_range(0, 3));
            ra = pick();
            rb = pick();
            issue(v, c, ra, rb);
            if (v) begin
                model(c, ra, rb, exp_r, o);
                exp_zf = (exp_r == 64'd0);
                exp_sf = exp_r[63];
                exp_of = o;
            end
            check("random", exp_r, exp_zf, exp_sf, exp_of, v);
        end

        // Reset asserted while an operation is presented after a busy state.
        issue(1'b1, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        check("pre_reset_ovf", 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1, 1'b1);
        rst_n = 1'b0;
        issue(1'b1, 2'b01, 64'd3, 64'd5);
        check("reset_in_flight", 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        issue(1'b0, 2'b00, 64'd0, 64'd0);
        check("after_reset_idle", 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
